mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 DEPTH, 4, maximum outstanding downstream transactions (power of two, 2..16).
REQ-002 CW, $clog2(DEPTH)+1, width of the outstanding counter.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 m_req  in  2  per-master request; bit0 = data master (M0), bit1 = uncached/inst master (M1).
REQ-006 m_wr  in  2  per-master write flag.
REQ-007 m_size  in  4  packed 2-bit sizes, M0 in [1:0].
REQ-008 m_addr  in  64  packed 32-bit addresses, M0 in [31:0].
REQ-009 m_wdata  in  64  packed 32-bit write data.
REQ-010 m_wstrb  in  8  packed 4-bit byte strobes.
REQ-011 m_rdata  out  32  read data, broadcast to both masters (= s_rdata).
REQ-012 m_addr_ok  out  2  per-master address accept.
REQ-013 m_data_ok  out  2  per-master completion.
REQ-014 s_req, s_wr, s_size[2], s_addr[32], s_wdata[32], s_wstrb[4]  out  downstream sram-like request of the granted master.
REQ-015 s_rdata  in  32  downstream read data.
REQ-016 s_addr_ok, s_data_ok  in  1 each  downstream accept / completion.
REQ-017 outstanding  out  CW  in-flight transaction count.
REQ-018 err_unexp  out  1  sticky flag: s_data_ok received with nothing outstanding.

Function
REQ-019 The block SHALL share one sram-like downstream port between M0 and M1; a transaction is accepted in the cycle s_req && s_addr_ok.
REQ-020 Grant SHALL be combinational from a registered state: if lock set, grant = locked master; else a single requester wins; with both requesting, the master not named by last_gnt wins (round-robin).
REQ-021 s_req SHALL equal m_req[grant] && (outstanding < DEPTH); all other s_* outputs SHALL mux the granted master's fields.
REQ-022 m_addr_ok[i] SHALL be s_addr_ok && s_req && grant==i; the other bit SHALL be 0.
REQ-023 Lock SHALL be set when s_req && !s_addr_ok, holding the grant until acceptance, and cleared on acceptance.
REQ-024 last_gnt SHALL update to the granted master only on acceptance.
REQ-025 On acceptance the granted master id SHALL be pushed to an in-order id FIFO; on s_data_ok the head SHALL be popped and m_data_ok[head] = 1 in that cycle (zero added latency).
REQ-026 Push and pop in the same cycle SHALL leave outstanding unchanged and both operations SHALL take effect.
REQ-027 At outstanding == DEPTH, s_req SHALL be 0 and no m_addr_ok SHALL assert until a pop; a pop and a new acceptance in the same cycle SHALL NOT occur at full (no combinational s_data_ok-to-s_req path).
REQ-028 FIFO pointers SHALL wrap modulo DEPTH; outstanding = push count minus pop count, 0..DEPTH.
REQ-029 s_data_ok with outstanding == 0 SHALL set err_unexp, drive m_data_ok = 0 and leave pointers unchanged.
REQ-030 m_req deasserting while locked is a master protocol violation; the block SHALL keep lock until acceptance regardless.

Reset
REQ-031 Under rst: outstanding = 0, FIFO pointers = 0, lock = 0, last_gnt = M1 (so M0 wins the first tie), err_unexp = 0.
REQ-032 While rst is high s_req, m_addr_ok and m_data_ok SHALL be 0; in-flight downstream responses are discarded.

Structure
REQ-033 Master id constants (M0 = 0, M1 = 1), NREQ = 2 and the sram-like size encoding SHALL live in the shared memory-interface package.
REQ-034 The id FIFO SHALL be a sub-module arb_order_fifo (DEPTH x 1 bit, push/pop/count/head); grant, lock and muxing stay in the top.

Verification
REQ-035 Both request from reset, s_addr_ok = 1 constantly -> accepts M0, M1, M0, M1; outstanding climbs 1..4 then s_req = 0.
REQ-036 M0 read with s_addr_ok low for 3 cycles while M1 raises req -> grant stays M0, m_addr_ok[0] on cycle 4, M1 accepted next.
REQ-037 Issue M1, M0, M1 then return three s_data_ok with rdata 0xA, 0xB, 0xC -> m_data_ok = 2'b10, 2'b01, 2'b10 with matching m_rdata.
REQ-038 DEPTH = 4 full, pop plus M0 request -> acceptance only in the cycle after the pop; then 6 further push/pop pairs -> ids correct across wrap.
REQ-039 s_data_ok with outstanding = 0 -> err_unexp = 1 and stays 1; m_data_ok = 0; rst -> err_unexp = 0.
REQ-040 rst asserted with 3 outstanding -> next cycle outstanding = 0, lock = 0, no m_data_ok.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared memory-interface definitions: master ids,
// requester count and sram-like transfer size encoding.
package mem_port_arbiter_pkg;

    localparam int NREQ = 2;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } sram_size_e;

    // Round-robin tie break: the master that did not win last.
    function automatic logic rr_pick(input logic last);
        return (last == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/arb_order_fifo.sv
// In-order id FIFO: remembers which master owns each
// in-flight downstream transaction, oldest at the head.
module arb_order_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          id_i,
    output logic          head_o,
    output logic [CW-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && (cnt_q != CW'(DEPTH));

    // Next-state: pointers wrap naturally at DEPTH (power of two).
    always_comb begin
        mem_d = mem_q;
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wp_q] = id_i;
            wp_d        = wp_q + PW'(1);
        end
        if (do_pop) begin
            rp_d = rp_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = mem_q[rp_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter onto one sram-like port: round-robin
// grant, lock while stalled, in-order completion routing.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   m_req,
    input  logic [NREQ-1:0]   m_wr,
    input  logic [3:0]        m_size,
    input  logic [63:0]       m_addr,
    input  logic [63:0]       m_wdata,
    input  logic [7:0]        m_wstrb,
    output logic [31:0]       m_rdata,
    output logic [NREQ-1:0]   m_addr_ok,
    output logic [NREQ-1:0]   m_data_ok,
    output logic              s_req,
    output logic              s_wr,
    output logic [1:0]        s_size,
    output logic [31:0]       s_addr,
    output logic [31:0]       s_wdata,
    output logic [3:0]        s_wstrb,
    input  logic [31:0]       s_rdata,
    input  logic              s_addr_ok,
    input  logic              s_data_ok,
    output logic [CW-1:0]     outstanding,
    output logic              err_unexp
);

    logic lock_q, lock_d;
    logic lock_id_q, lock_id_d;
    logic last_gnt_q, last_gnt_d;
    logic err_q, err_d;
    logic gnt;
    logic full;
    logic empty;
    logic accept;
    logic pop_ok;
    logic head_id;

    assign full  = (outstanding == CW'(DEPTH));
    assign empty = (outstanding == '0);

    // Grant: locked master first, else lone requester, else RR.
    always_comb begin
        gnt = M0;
        if (lock_q) begin
            gnt = lock_id_q;
        end else begin
            case (m_req)
                2'b01:   gnt = M0;
                2'b10:   gnt = M1;
                2'b11:   gnt = rr_pick(last_gnt_q);
                default: gnt = M0;
            endcase
        end
    end

    assign s_req   = !rst && m_req[gnt] && !full;
    assign s_wr    = m_wr[gnt];
    assign s_size  = gnt ? m_size[3:2]    : m_size[1:0];
    assign s_addr  = gnt ? m_addr[63:32]  : m_addr[31:0];
    assign s_wdata = gnt ? m_wdata[63:32] : m_wdata[31:0];
    assign s_wstrb = gnt ? m_wstrb[7:4]   : m_wstrb[3:0];

    assign accept = s_req && s_addr_ok;
    assign pop_ok = !rst && s_data_ok && !empty;

    assign m_addr_ok = accept ? (gnt ? 2'b10 : 2'b01) : 2'b00;
    assign m_data_ok = pop_ok ? (head_id ? 2'b10 : 2'b01) : 2'b00;
    assign m_rdata   = s_rdata;
    assign err_unexp = err_q;

    // Next-state for lock, round-robin pointer and error flag.
    always_comb begin
        lock_d     = lock_q;
        lock_id_d  = lock_id_q;
        last_gnt_d = last_gnt_q;
        err_d      = err_q;
        if (accept) begin
            lock_d     = 1'b0;
            last_gnt_d = gnt;
        end else if (s_req) begin
            lock_d    = 1'b1;
            lock_id_d = gnt;
        end
        if (s_data_ok && empty) begin
            err_d = 1'b1;
        end
    end

    // Arbitration state; M1 as last winner so M0 wins first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q     <= 1'b0;
            lock_id_q  <= M0;
            last_gnt_q <= M1;
            err_q      <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            last_gnt_q <= last_gnt_d;
            err_q      <= err_d;
        end
    end

    arb_order_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_order (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .pop_i   (pop_ok),
        .id_i    (gnt),
        .head_o  (head_id),
        .count_o (outstanding)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed vectors,
// expectations queued by the driver, checked by a monitor.
module tb_mem_port_arbiter;

    localparam logic [31:0] A0 = 32'h0000_A000;
    localparam logic [31:0] A1 = 32'h1000_B004;
    localparam logic [31:0] D0 = 32'h1234_5678;
    localparam logic [31:0] D1 = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_req;
    logic [1:0]  m_wr;
    logic [3:0]  m_size;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic [1:0]  m_addr_ok;
    logic [1:0]  m_data_ok;
    logic        s_req;
    logic        s_wr;
    logic [1:0]  s_size;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [31:0] s_rdata;
    logic        s_addr_ok;
    logic        s_data_ok;
    logic [2:0]  outstanding;
    logic        err_unexp;

    int vecs = 0;
    int errs = 0;

    logic        acc_q[$];
    logic        ord_q[$];
    logic [31:0] rd_q[$];

    mem_port_arbiter #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .m_req       (m_req),
        .m_wr        (m_wr),
        .m_size      (m_size),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_wstrb     (m_wstrb),
        .m_rdata     (m_rdata),
        .m_addr_ok   (m_addr_ok),
        .m_data_ok   (m_data_ok),
        .s_req       (s_req),
        .s_wr        (s_wr),
        .s_size      (s_size),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_wstrb     (s_wstrb),
        .s_rdata     (s_rdata),
        .s_addr_ok   (s_addr_ok),
        .s_data_ok   (s_data_ok),
        .outstanding (outstanding),
        .err_unexp   (err_unexp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_acc(input logic id);
        acc_q.push_back(id);
        ord_q.push_back(id);
    endtask

    task automatic data_ret(input logic [31:0] v);
        s_data_ok = 1'b1;
        s_rdata   = v;
        rd_q.push_back(v);
    endtask

    task automatic do_reset();
        chk("leftover_acc", 32'(acc_q.size()), 0);
        chk("leftover_rsp", 32'(ord_q.size()), 0);
        m_req     = 2'b00;
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        rst       = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Monitor: compare every accept / completion against the queues.
    always @(negedge clk) begin
        logic e;
        if (rst) begin
            chk("rst_addr_ok", 32'(m_addr_ok), 0);
            chk("rst_data_ok", 32'(m_data_ok), 0);
        end else begin
            if (m_addr_ok != 2'b00) begin
                if (acc_q.size() == 0) begin
                    chk("acc_unexp", 32'(m_addr_ok), 0);
                end else begin
                    e = acc_q.pop_front();
                    chk("acc_id", 32'(m_addr_ok), e ? 2 : 1);
                    chk("acc_addr", s_addr, e ? A1 : A0);
                    chk("acc_wdata", s_wdata, e ? D1 : D0);
                    chk("acc_wr", 32'(s_wr), e ? 1 : 0);
                    chk("acc_size", 32'(s_size), e ? 2 : 1);
                    chk("acc_strb", 32'(s_wstrb), e ? 32'hF : 32'h3);
                end
            end
            if (m_data_ok != 2'b00) begin
                if (ord_q.size() == 0 || rd_q.size() == 0) begin
                    chk("data_unexp", 32'(m_data_ok), 0);
                end else begin
                    e = ord_q.pop_front();
                    chk("data_id", 32'(m_data_ok), e ? 2 : 1);
                    chk("data_rdata", m_rdata, rd_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        m_req     = 2'b11;
        m_wr      = 2'b10;
        m_size    = 4'b1001;
        m_addr    = {A1, A0};
        m_wdata   = {D1, D0};
        m_wstrb   = 8'hF3;
        s_rdata   = 32'h0;
        s_addr_ok = 1'b1;
        s_data_ok = 1'b1;

        // Reset state with requests and responses active
        step();
        @(negedge clk);
        chk("rst_s_req", 32'(s_req), 0);
        step();
        chk("rst_outstanding", 32'(outstanding), 0);
        chk("rst_err", 32'(err_unexp), 0);
        rst       = 1'b0;
        s_data_ok = 1'b0;

        // Both requesting: M0, M1, M0, M1 then full
        for (int i = 0; i < 4; i++) begin
            expect_acc(i[0]);
            @(negedge clk);
            chk("t1_out", 32'(outstanding), 32'(i));
            step();
        end
        @(negedge clk);
        chk("t1_full_sreq", 32'(s_req), 0);
        chk("t1_full_out", 32'(outstanding), 4);
        step();
        m_req = 2'b00;
        for (int i = 0; i < 4; i++) begin
            data_ret(32'h10 + 32'(i));
            step();
        end
        s_data_ok = 1'b0;
        @(negedge clk);
        chk("t1_drain", 32'(outstanding), 0);

        // M0 stalled three cycles while M1 joins
        do_reset();
        m_req     = 2'b01;
        s_addr_ok = 1'b0;
        @(negedge clk);
        chk("t2_sreq", 32'(s_req), 1);
        chk("t2_addr", s_addr, A0);
        step();
        m_req = 2'b11;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t2_hold", s_addr, A0);
            step();
        end
        s_addr_ok = 1'b1;
        expect_acc(1'b0);
        step();
        expect_acc(1'b1);
        step();
        // M1 stalled alone, then M0 joins: lock keeps M1
        m_req     = 2'b10;
        s_addr_ok = 1'b0;
        @(negedge clk);
        chk("t2_m1", s_addr, A1);
        step();
        m_req = 2'b11;
        @(negedge clk);
        chk("t2_lock", s_addr, A1);
        step();
        s_addr_ok = 1'b1;
        expect_acc(1'b1);
        step();
        m_req = 2'b00;
        @(negedge clk);
        chk("t2_out", 32'(outstanding), 3);
        for (int i = 0; i < 3; i++) begin
            data_ret(32'h20 + 32'(i));
            step();
        end
        s_data_ok = 1'b0;

        // M1, M0, M1 then completions 0xA, 0xB, 0xC
        do_reset();
        s_addr_ok = 1'b1;
        m_req = 2'b10; expect_acc(1'b1); step();
        m_req = 2'b01; expect_acc(1'b0); step();
        m_req = 2'b10; expect_acc(1'b1); step();
        m_req = 2'b00;
        data_ret(32'hA); step();
        data_ret(32'hB); step();
        data_ret(32'hC); step();
        s_data_ok = 1'b0;

        // Full, pop with M0 waiting, then wrap pairs
        do_reset();
        s_addr_ok = 1'b1;
        m_req     = 2'b01;
        for (int i = 0; i < 4; i++) begin
            expect_acc(1'b0);
            step();
        end
        @(negedge clk);
        chk("t4_full_sreq", 32'(s_req), 0);
        step();
        data_ret(32'h100);
        @(negedge clk);
        chk("t4_pop_no_acc", 32'(m_addr_ok), 0);
        step();
        s_data_ok = 1'b0;
        expect_acc(1'b0);
        @(negedge clk);
        chk("t4_after_pop", 32'(s_req), 1);
        chk("t4_out3", 32'(outstanding), 3);
        step();
        m_req = 2'b00;
        data_ret(32'h101);
        step();
        for (int k = 0; k < 6; k++) begin
            m_req = k[0] ? 2'b10 : 2'b01;
            expect_acc(k[0]);
            data_ret(32'h200 + 32'(k));
            @(negedge clk);
            chk("t4_pair_out", 32'(outstanding), 3);
            step();
        end
        m_req = 2'b00;
        for (int i = 0; i < 3; i++) begin
            data_ret(32'h300 + 32'(i));
            step();
        end
        s_data_ok = 1'b0;
        @(negedge clk);
        chk("t4_drain", 32'(outstanding), 0);

        // Unexpected completion sets sticky error
        do_reset();
        s_data_ok = 1'b1;
        s_rdata   = 32'hDEAD;
        @(negedge clk);
        chk("t5_no_dok", 32'(m_data_ok), 0);
        step();
        s_data_ok = 1'b0;
        @(negedge clk);
        chk("t5_err", 32'(err_unexp), 1);
        chk("t5_out", 32'(outstanding), 0);
        repeat (3) step();
        @(negedge clk);
        chk("t5_sticky", 32'(err_unexp), 1);
        do_reset();
        @(negedge clk);
        chk("t5_err_clr", 32'(err_unexp), 0);
        s_addr_ok = 1'b1;
        m_req     = 2'b10;
        expect_acc(1'b1);
        step();
        m_req = 2'b00;
        data_ret(32'h55);
        step();
        s_data_ok = 1'b0;

        // Reset with three in flight and M1 locked
        do_reset();
        s_addr_ok = 1'b1;
        m_req = 2'b11;
        expect_acc(1'b0); step();
        expect_acc(1'b1); step();
        expect_acc(1'b0); step();
        m_req     = 2'b10;
        s_addr_ok = 1'b0;
        step();
        @(negedge clk);
        chk("t6_out3", 32'(outstanding), 3);
        chk("t6_locked", s_addr, A1);
        step();
        ord_q.delete();
        rst       = 1'b1;
        s_data_ok = 1'b1;
        m_req     = 2'b11;
        @(negedge clk);
        chk("t6_rst_sreq", 32'(s_req), 0);
        step();
        chk("t6_rst_out", 32'(outstanding), 0);
        step();
        rst       = 1'b0;
        s_data_ok = 1'b0;
        s_addr_ok = 1'b1;
        expect_acc(1'b0);
        step();
        m_req = 2'b00;
        data_ret(32'hEE);
        step();
        s_data_ok = 1'b0;
        @(negedge clk);
        chk("t6_final_out", 32'(outstanding), 0);
        chk("end_acc", 32'(acc_q.size()), 0);
        chk("end_rsp", 32'(ord_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
